imem_boot_loader: RTL and testbench

- Boot controller for the single-cycle RV32 core: receives a program image as a byte stream and sequences the core's instruction-memory write port (insMemEn/insMemAddr/insMemDataIn).
- Holds the core in reset while loading, then releases it.
- Sits between a byte source (UART receiver or test bench) and the processor's load port and reset input.

---
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into instruction-memory
// writes, holding the core in reset until the image is in place.
module imem_boot_loader #(
   parameter int WIDTH       = 32,
   parameter int IMEM_DEPTH  = 512,
   parameter int HOLD_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             insMemEn,
   output logic [WIDTH-1:0] insMemAddr,
   output logic [WIDTH-1:0] insMemDataIn,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      word_cnt
);

   localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [16:0] DEPTH_MAX = 17'(IMEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_FLUSH,
      S_RUN,
      S_ERROR
   } state_t;

   state_t            state;
   logic [15:0]       len_q;
   logic [1:0]        byte_cnt;
   logic [23:0]       asm_q;
   logic [HOLD_W-1:0] hold_q;

   logic        accept;
   logic        load_req;
   logic [15:0] len_full;
   logic        last_word;

   assign accept    = in_valid & in_ready;
   assign load_req  = start & ((state == S_IDLE) | (state == S_RUN) | (state == S_ERROR));
   assign len_full  = {in_data, len_q[7:0]};
   assign last_word = ((word_cnt + 16'd1) == len_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         byte_cnt     <= '0;
         asm_q        <= '0;
         hold_q       <= '0;
         in_ready     <= 1'b0;
         insMemEn     <= 1'b0;
         insMemAddr   <= '0;
         insMemDataIn <= '0;
         cpu_reset    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         word_cnt     <= '0;
      end else begin
         // NOTE: the write strobe defaults low every cycle so it can only ever be a one-cycle pulse;
         // later non-blocking assignments in this block override the default.
         insMemEn <= 1'b0;

         if (abort) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
         end else if (load_req) begin
            state     <= S_LEN0;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            len_q     <= '0;
         end else begin
            case (state)
               S_LEN0: begin
                  if (accept) begin
                     len_q[7:0] <= in_data;
                     state      <= S_LEN1;
                  end
               end

               S_LEN1: begin
                  if (accept) begin
                     len_q[15:8] <= in_data;
                     if (len_full == 16'd0) begin
                        state    <= S_FLUSH;
                        in_ready <= 1'b0;
                        hold_q   <= '0;
                     end else if ({1'b0, len_full} > DEPTH_MAX) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end

               S_DATA: begin
                  if (accept) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        insMemEn     <= 1'b1;
                        insMemDataIn <= WIDTH'({in_data, asm_q});
                        insMemAddr   <= WIDTH'(word_cnt);
                        word_cnt     <= word_cnt + 16'd1;
                        // Drop ready together with the final strobe so no byte past the image is taken.
                        if (last_word) begin
                           state    <= S_FLUSH;
                           in_ready <= 1'b0;
                           hold_q   <= '0;
                        end
                     end else begin
                        asm_q <= {in_data, asm_q[23:8]};
                     end
                  end
               end

               S_FLUSH: begin
                  if (hold_q == HOLD_LAST) begin
                     state     <= S_RUN;
                     cpu_reset <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end

               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader: a stream-level model queues expected writes,
// and a monitor pops and compares them whenever the write strobe is seen.
module tb_imem_boot_loader;

   localparam int WIDTH = 32;
   localparam int DEPTH = 512;
   localparam int HOLD  = 4;

   logic             clock    = 1'b0;
   logic             reset    = 1'b0;
   logic             start    = 1'b0;
   logic             abort    = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data  = 8'h00;
   logic             in_ready;
   logic             insMemEn;
   logic [WIDTH-1:0] insMemAddr;
   logic [WIDTH-1:0] insMemDataIn;
   logic             cpu_reset;
   logic             busy;
   logic             done;
   logic             error;
   logic [15:0]      word_cnt;

   imem_boot_loader #(.WIDTH(WIDTH), .IMEM_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .insMemEn    (insMemEn),
      .insMemAddr  (insMemAddr),
      .insMemDataIn(insMemDataIn),
      .cpu_reset   (cpu_reset),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .word_cnt    (word_cnt)
   );

   always #5 clock = ~clock;

   typedef logic [7:0]  bytes_t[$];
   typedef logic [31:0] words_t[$];
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc   = 0;
   int  last_pulse_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expected write.
   initial begin
      forever begin
         @(negedge clock);
         if (insMemEn === 1'b1) begin
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                        insMemAddr, insMemDataIn);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write_addr", 64'(insMemAddr), 64'(e.addr));
               check("write_data", 64'(insMemDataIn), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: the stream is a 16-bit LE count followed by that many LE words.
   function automatic int model_len(input bytes_t img);
      return int'(img[0]) + 256 * int'(img[1]);
   endfunction

   function automatic void model_expect(input bytes_t img);
      int n;
      n = model_len(img);
      if (n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = i;
            e.data = 32'(img[2 + 4*i]) | (32'(img[3 + 4*i]) << 8) |
                     (32'(img[4 + 4*i]) << 16) | (32'(img[5 + 4*i]) << 24);
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic bytes_t make_image(input words_t words);
      bytes_t b;
      int     n;
      n = words.size();
      b.push_back(8'(n & 255));
      b.push_back(8'((n >> 8) & 255));
      foreach (words[i]) begin
         for (int k = 0; k < 4; k++) b.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
      end
      return b;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),     64'd0);
      check({tag, "_insMemEn"},  64'(insMemEn),     64'd0);
      check({tag, "_addr"},      64'(insMemAddr),   64'd0);
      check({tag, "_data"},      64'(insMemDataIn), 64'd0);
      check({tag, "_cpu_reset"}, 64'(cpu_reset),    64'd1);
      check({tag, "_busy"},      64'(busy),         64'd0);
      check({tag, "_done"},      64'(done),         64'd0);
      check({tag, "_error"},     64'(error),        64'd0);
      check({tag, "_word_cnt"},  64'(word_cnt),     64'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_cpu_reset", 64'(cpu_reset), 64'd1);
      check("start_busy",      64'(busy),      64'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (t >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL in_ready_timeout: got in_ready %0b, expected 1 within 100 cycles", in_ready);
      end
      @(negedge clock);
   endtask

   task automatic run_load(input bytes_t img, input int gap_mode, input int glitch_at);
      int n;
      int g;
      n = model_len(img);
      model_expect(img);
      pulse_start();
      for (int i = 0; i < img.size(); i++) begin
         if (i == glitch_at) begin
            in_valid = 1'b0;
            start    = 1'b1;
            @(negedge clock);
            start = 1'b0;
         end
         send_byte(img[i]);
         if (i == img.size() - 1 && n > 0 && n <= DEPTH) begin
            check("last_write_in_ready", 64'(in_ready), 64'd0);
            check("last_write_strobe",   64'(insMemEn), 64'd1);
         end
         g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
         if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) @(negedge clock);
         end
      end
   endtask

   task automatic wait_run(input int n_words, input bit has_write);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got done %0b, expected 1 within 200 cycles", done);
      end
      if (has_write) check("cpu_reset_release_delay", 64'(cyc - last_pulse_cyc), 64'(HOLD));
      check("run_cpu_reset", 64'(cpu_reset), 64'd0);
      check("run_word_cnt",  64'(word_cnt),  64'(n_words));
      check("run_busy",      64'(busy),      64'd0);
      in_valid = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      bytes_t img;
      words_t w;
      int     n;
      int     gl;

      repeat (3) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b1;
      @(negedge clock);
      check("idle_in_ready", 64'(in_ready), 64'd0);

      // Two-word image with in_valid held high.
      img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
      run_load(img, 0, -1);
      wait_run(2, 1'b1);

      // Same image with in_valid toggling every cycle.
      run_load(img, 1, -1);
      wait_run(2, 1'b1);

      // Oversized header, then an empty image.
      img = '{8'h01, 8'h02};
      run_load(img, 0, -1);
      check("oversize_error",    64'(error),    64'd1);
      check("oversize_in_ready", 64'(in_ready), 64'd0);
      check("oversize_busy",     64'(busy),     64'd0);
      repeat (3) @(negedge clock);
      in_valid = 1'b0;
      check("oversize_error_held", 64'(error), 64'd1);
      img = '{8'h00, 8'h00};
      run_load(img, 0, -1);
      wait_run(0, 1'b0);

      // Abort coinciding with byte 3 of word 0.
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      in_valid = 1'b1;
      in_data  = 8'h44;
      abort    = 1'b1;
      @(negedge clock);
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_insMemEn",  64'(insMemEn),  64'd0);
      check("abort_busy",      64'(busy),      64'd0);
      check("abort_in_ready",  64'(in_ready),  64'd0);
      check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
      check("abort_done",      64'(done),      64'd0);
      repeat (2) @(negedge clock);

      // Later load with a start pulse in DATA that must be ignored.
      w = '{32'hCAFEF00D, 32'h12345678};
      img = make_image(w);
      run_load(img, 0, 5);
      wait_run(2, 1'b1);

      // Reload from RUN with a single word.
      img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(img, 0, -1);
      wait_run(1, 1'b1);

      // Randomised images, gap patterns and ignored start pulses.
      for (int r = 0; r < 8; r++) begin
         w = {};
         n = int'($urandom_range(0, 6));
         for (int i = 0; i < n; i++) w.push_back($urandom);
         img = make_image(w);
         gl = ($urandom_range(0, 2) == 0 && n > 0) ? int'($urandom_range(3, img.size() - 1)) : -1;
         run_load(img, int'($urandom_range(0, 2)), gl);
         wait_run(n, n > 0);
      end

      // Reset mid-DATA after six bytes: only word 0 lands, then nothing more.
      w = '{$urandom, $urandom, $urandom};
      img = make_image(w);
      begin
         wr_t e;
         e.addr = 0;
         e.data = w[0];
         exp_q.push_back(e);
      end
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(img[i]);
      in_valid = 1'b0;
      @(negedge clock);
      #2 reset = 1'b0;
      #1 check_reset_values("mid_data_reset");
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clock);
      end
      in_valid = 1'b0;
      check("post_reset_busy",     64'(busy),     64'd0);
      check("post_reset_in_ready", 64'(in_ready), 64'd0);
      check("post_reset_word_cnt", 64'(word_cnt), 64'd0);

      check("expected_writes_outstanding", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
